// File: rtl/i2c_master_arbiter_pkg.sv
// Shared definitions for the i2c_master arbiter: master status/control/mode register
// bit positions and the arbiter FSM state encoding.
package i2c_master_arbiter_pkg;

  // i2c_master status register bit positions
  localparam int unsigned StatBusy   = 4;
  localparam int unsigned StatTxDone = 3;
  localparam int unsigned StatRxDone = 2;
  localparam int unsigned StatTxErr  = 1;
  localparam int unsigned StatRxErr  = 0;

  // Either error flag in the status register marks the transaction failed
  localparam logic [4:0] StatErrMask = 5'b00011;

  // i2c_master control register bit positions
  localparam int unsigned CtrlStart = 3;
  localparam int unsigned CtrlClear = 2;

  // i2c_master mode register bit positions
  localparam int unsigned ModeAddr = 3;
  localparam int unsigned ModeRw   = 2;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StGrant    = 3'd1,
    StStart    = 3'd2,
    StWaitBusy = 3'd3,
    StRun      = 3'd4,
    StClear    = 3'd5,
    StResp     = 3'd6
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Scans req_i starting at ptr_i, wrapping NUM_REQ-1 -> 0, and returns the first asserted
// requester as a one-hot grant plus its binary index.
//   req_i   : request vector
//   ptr_i   : index with highest priority
//   gnt_o   : one-hot grant (all zero when no request)
//   idx_o   : binary index of the granted requester
//   valid_o : at least one request was found
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               valid_o
);

  logic [IdxW:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // One spare bit holds ptr + i before the wrap back into range
      pos = {1'b0, ptr_i} + (IdxW + 1)'(i);
      if (pos >= (IdxW + 1)'(NUM_REQ)) begin
        pos = pos - (IdxW + 1)'(NUM_REQ);
      end
      if (!found && req_i[pos[IdxW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[pos[IdxW-1:0]]   = 1'b1;
        idx_o                  = pos[IdxW-1:0];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin scheduler sharing one i2c_master between NUM_REQ requesters.
// Latches the granted requester's descriptor, drives the master's control/mode registers,
// routes TX/RX bytes, clears master status after each transaction and returns a
// per-requester done/error pulse. A watchdog covers a master that never goes busy or
// never finishes.
//   i_clk, i_rst          : clock, asynchronous active-high reset
//   i_req*                : per-requester request level and packed descriptors
//   o_grant               : one-hot owner of the master for the whole transaction
//   o_tx_next, o_rx_*     : per-requester TX advance and RX delivery pulses
//   o_done, o_err         : per-requester completion / error pulses
//   o_m_*, i_m_*          : interface to the shared i2c_master
module i2c_master_arbiter
  import i2c_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 64,
  parameter int unsigned XFER_TIMEOUT  = 2_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [10*NUM_REQ-1:0] i_req_addr,
  input  logic [8*NUM_REQ-1:0] i_req_cnt,
  input  logic [2*NUM_REQ-1:0] i_req_mode,
  input  logic [8*NUM_REQ-1:0] i_req_tx_data,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_tx_next,
  output logic [NUM_REQ-1:0]   o_rx_valid,
  output logic [7:0]           o_rx_data,
  output logic [NUM_REQ-1:0]   o_done,
  output logic [NUM_REQ-1:0]   o_err,
  output logic [9:0]           o_m_slave_addr,
  output logic [7:0]           o_m_byte_cnt,
  output logic [3:0]           o_m_control_reg,
  output logic [3:0]           o_m_mode_reg,
  output logic [7:0]           o_m_tx_data,
  input  logic                 i_m_tx_data_needed,
  input  logic                 i_m_rx_data_valid,
  input  logic [7:0]           i_m_rx_data,
  input  logic [4:0]           i_m_status_reg
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TmrW = $clog2(XFER_TIMEOUT + 1);
  localparam logic [TmrW-1:0] StartLast = TmrW'(START_TIMEOUT - 1);
  localparam logic [TmrW-1:0] XferLast  = TmrW'(XFER_TIMEOUT - 1);

  // Per-requester views of the packed descriptor buses
  logic [9:0] req_addr [NUM_REQ];
  logic [7:0] req_cnt  [NUM_REQ];
  logic [1:0] req_mode [NUM_REQ];
  logic [7:0] req_tx   [NUM_REQ];

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_addr[k] = i_req_addr[10*k +: 10];
      req_cnt[k]  = i_req_cnt[8*k +: 8];
      req_mode[k] = i_req_mode[2*k +: 2];
      req_tx[k]   = i_req_tx_data[8*k +: 8];
    end
  end

  arb_state_e state_q, state_d;

  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]    gidx_q, gidx_d;
  logic [9:0]         addr_q, addr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;  // {addr_mode, rw}
  logic               err_q, err_d;
  logic [7:0]         rx_cnt_q, rx_cnt_d;
  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic               start_q, start_d;
  logic               clear_q, clear_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0] tx_next_q, tx_next_d;
  logic [NUM_REQ-1:0] rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_pulse_q, err_pulse_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i  (i_req),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  logic busy;
  logic start_to;
  logic xfer_to;
  logic pick_zero;
  logic clr_err;

  assign busy      = i_m_status_reg[StatBusy];
  assign start_to  = (tmr_q == StartLast);
  assign xfer_to   = (tmr_q == XferLast);
  assign pick_zero = (req_cnt[pick_idx] == 8'd0);

  // Completion check against the status the master still holds while we clear it
  always_comb begin
    clr_err = |(i_m_status_reg & StatErrMask);
    if (mode_q[0]) begin
      clr_err = clr_err | (rx_cnt_q != cnt_q) | ~i_m_status_reg[StatRxDone];
    end else begin
      clr_err = clr_err | ~i_m_status_reg[StatTxDone];
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|i_req) state_d = StGrant;
      end
      StGrant: begin
        // Request may have dropped between IDLE and GRANT
        if (!pick_valid)    state_d = StIdle;
        else if (pick_zero) state_d = StResp;
        else                state_d = StStart;
      end
      StStart: state_d = StWaitBusy;
      StWaitBusy: begin
        if (busy)          state_d = StRun;
        else if (start_to) state_d = StClear;
      end
      StRun: begin
        if (!busy || xfer_to) state_d = StClear;
      end
      StClear: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-state logic
  always_comb begin
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    err_d       = err_q;
    rx_cnt_d    = rx_cnt_q;
    tx_next_d   = '0;
    rx_valid_d  = '0;
    rx_data_d   = rx_data_q;
    done_d      = '0;
    err_pulse_d = '0;
    tx_data_d   = (grant_q != '0) ? req_tx[gidx_q] : 8'h00;
    start_d     = (state_d == StStart);
    clear_d     = (state_d == StClear);

    // Timer restarts from zero on every state entry
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (tmr_q != '1) begin
      tmr_d = tmr_q + 1'b1;
    end else begin
      tmr_d = tmr_q;
    end

    unique case (state_q)
      StGrant: begin
        if (pick_valid) begin
          grant_d  = pick_gnt;
          gidx_d   = pick_idx;
          addr_d   = req_addr[pick_idx];
          cnt_d    = req_cnt[pick_idx];
          mode_d   = req_mode[pick_idx];
          rx_cnt_d = 8'd0;
          err_d    = pick_zero;
          // A zero-length request is rejected without touching the master
          if (pick_zero) begin
            done_d      = pick_gnt;
            err_pulse_d = pick_gnt;
          end
        end
      end
      StWaitBusy: begin
        if (!busy && start_to) err_d = 1'b1;
      end
      StRun: begin
        if (i_m_tx_data_needed) tx_next_d = grant_q;
        if (i_m_rx_data_valid) begin
          rx_valid_d = grant_q;
          rx_data_d  = i_m_rx_data;
          if (rx_cnt_q != 8'hff) rx_cnt_d = rx_cnt_q + 8'd1;
        end
        if (busy && xfer_to) err_d = 1'b1;
      end
      StClear: begin
        err_d       = err_q | clr_err;
        done_d      = grant_q;
        err_pulse_d = (err_q | clr_err) ? grant_q : '0;
      end
      StResp: begin
        grant_d = '0;
        ptr_d   = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      gidx_q      <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      err_q       <= 1'b0;
      rx_cnt_q    <= '0;
      tmr_q       <= '0;
      start_q     <= 1'b0;
      clear_q     <= 1'b0;
      tx_data_q   <= '0;
      tx_next_q   <= '0;
      rx_valid_q  <= '0;
      rx_data_q   <= '0;
      done_q      <= '0;
      err_pulse_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      rx_cnt_q    <= rx_cnt_d;
      tmr_q       <= tmr_d;
      start_q     <= start_d;
      clear_q     <= clear_d;
      tx_data_q   <= tx_data_d;
      tx_next_q   <= tx_next_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      done_q      <= done_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    o_m_control_reg            = '0;
    o_m_control_reg[CtrlStart] = start_q;
    o_m_control_reg[CtrlClear] = clear_q;
    o_m_mode_reg               = '0;
    o_m_mode_reg[ModeAddr]     = mode_q[1];
    o_m_mode_reg[ModeRw]       = mode_q[0];
  end

  assign o_grant        = grant_q;
  assign o_tx_next      = tx_next_q;
  assign o_rx_valid     = rx_valid_q;
  assign o_rx_data      = rx_data_q;
  assign o_done         = done_q;
  assign o_err          = err_pulse_q;
  assign o_m_slave_addr = addr_q;
  assign o_m_byte_cnt   = cnt_q;
  assign o_m_tx_data    = tx_data_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter with a cycle-based i2c_master model and a
// scoreboard of expected done/err and RX results.
module tb_i2c_master_arbiter;

  localparam int unsigned NR = 4;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NR-1:0]     i_req;
  logic [10*NR-1:0]  i_req_addr;
  logic [8*NR-1:0]   i_req_cnt;
  logic [2*NR-1:0]   i_req_mode;
  logic [8*NR-1:0]   i_req_tx_data;
  logic [NR-1:0]     o_grant;
  logic [NR-1:0]     o_tx_next;
  logic [NR-1:0]     o_rx_valid;
  logic [7:0]        o_rx_data;
  logic [NR-1:0]     o_done;
  logic [NR-1:0]     o_err;
  logic [9:0]        o_m_slave_addr;
  logic [7:0]        o_m_byte_cnt;
  logic [3:0]        o_m_control_reg;
  logic [3:0]        o_m_mode_reg;
  logic [7:0]        o_m_tx_data;
  logic              i_m_tx_data_needed;
  logic              i_m_rx_data_valid;
  logic [7:0]        i_m_rx_data;
  logic [4:0]        i_m_status_reg;

  i2c_master_arbiter #(
    .NUM_REQ      (NR),
    .START_TIMEOUT(64),
    .XFER_TIMEOUT (2_000_000)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_req             (i_req),
    .i_req_addr        (i_req_addr),
    .i_req_cnt         (i_req_cnt),
    .i_req_mode        (i_req_mode),
    .i_req_tx_data     (i_req_tx_data),
    .o_grant           (o_grant),
    .o_tx_next         (o_tx_next),
    .o_rx_valid        (o_rx_valid),
    .o_rx_data         (o_rx_data),
    .o_done            (o_done),
    .o_err             (o_err),
    .o_m_slave_addr    (o_m_slave_addr),
    .o_m_byte_cnt      (o_m_byte_cnt),
    .o_m_control_reg   (o_m_control_reg),
    .o_m_mode_reg      (o_m_mode_reg),
    .o_m_tx_data       (o_m_tx_data),
    .i_m_tx_data_needed(i_m_tx_data_needed),
    .i_m_rx_data_valid (i_m_rx_data_valid),
    .i_m_rx_data       (i_m_rx_data),
    .i_m_status_reg    (i_m_status_reg)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: done entries are idx*2+err, RX entries are idx*256+byte
  int exp_done[$];
  int exp_rx[$];
  int gaps[$];

  int         cyc = 0;
  int         n_start = 0;
  int         n_clear = 0;
  int         start_cyc = 0;
  int         n_txnext [NR];
  logic [7:0] tx_byte  [NR];
  logic [9:0] last_addr;
  logic [3:0] last_mode;
  logic [7:0] last_cnt;

  // Master model state
  bit         m_active = 0;
  int         m_t, m_k, m_events, m_cnt;
  bit         m_rw;
  bit         clr_prev = 0;
  bit         never_busy = 0;
  bit         short_read = 0;
  logic [7:0] rx_bytes [8];

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step();
    int k;
    int obs;
    @(negedge i_clk);
    cyc++;
    // Monitor
    if (o_grant != '0) check("grant_onehot", 32'($onehot(o_grant)), 1);
    if (o_m_control_reg[3]) begin
      n_start++;
      start_cyc = cyc;
      last_addr = o_m_slave_addr;
      last_mode = o_m_mode_reg;
      last_cnt  = o_m_byte_cnt;
    end
    if (o_m_control_reg[2]) begin
      n_clear++;
      gaps.push_back(cyc - start_cyc);
    end
    for (int i = 0; i < NR; i++) begin
      if (o_tx_next[i]) begin
        n_txnext[i]++;
        tx_byte[i] = tx_byte[i] + 8'd1;
      end
    end
    if (o_rx_valid != '0) begin
      obs = oh2idx(o_rx_valid) * 256 + int'(o_rx_data);
      if (exp_rx.size() == 0) check("rx_unexpected", obs, -1);
      else check("rx_byte", obs, exp_rx.pop_front());
    end
    if (o_done != '0) begin
      k   = oh2idx(o_done);
      obs = k * 2 + int'(o_err[k]);
      if (exp_done.size() == 0) check("done_unexpected", obs, -1);
      else check("done", obs, exp_done.pop_front());
      i_req[k] = 1'b0;
    end
    if ((o_err & ~o_done) != '0) check("err_without_done", 32'(o_err), 32'(o_done));

    // Master model
    i_m_tx_data_needed = 1'b0;
    i_m_rx_data_valid  = 1'b0;
    if (clr_prev) i_m_status_reg[3:0] = 4'b0;
    clr_prev = o_m_control_reg[2];
    if (o_m_control_reg[3]) begin
      if (never_busy) begin
        never_busy = 0;
      end else begin
        m_active = 1;
        m_t      = 0;
        m_k      = 0;
        m_cnt    = int'(o_m_byte_cnt);
        m_rw     = o_m_mode_reg[2];
        m_events = short_read ? m_cnt - 1 : m_cnt;
      end
    end else if (m_active) begin
      m_t++;
      if (m_t == 2) begin
        i_m_status_reg[4] = 1'b1;
      end else if (m_t > 2) begin
        if (m_k < m_events) begin
          if (m_t % 2 == 1) begin
            if (m_rw) begin
              i_m_rx_data_valid = 1'b1;
              i_m_rx_data       = rx_bytes[m_k];
            end else begin
              check("tx_byte", 32'(o_m_tx_data), 32'(tx_byte[oh2idx(o_grant)]));
              i_m_tx_data_needed = 1'b1;
            end
            m_k++;
          end
        end else if (m_t % 2 == 0) begin
          i_m_status_reg = {1'b0, !m_rw, m_rw && (m_k == m_cnt), 2'b00};
          m_active = 0;
        end
      end
    end
    for (int i = 0; i < NR; i++) i_req_tx_data[8*i +: 8] = tx_byte[i];
  endtask

  task automatic set_req(input int k, input logic [9:0] a, input logic [7:0] c,
                         input logic [1:0] m);
    i_req_addr[10*k +: 10] = a;
    i_req_cnt[8*k +: 8]    = c;
    i_req_mode[2*k +: 2]   = m;
    i_req[k]               = 1'b1;
  endtask

  task automatic drain(input int budget);
    int i = 0;
    while (exp_done.size() != 0 && i < budget) begin
      step();
      i++;
    end
    check("drain_done_queue", exp_done.size(), 0);
    check("drain_rx_queue", exp_rx.size(), 0);
    exp_done.delete();
    exp_rx.delete();
    repeat (3) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(o_grant), 0);
    check({tag, "_done"}, 32'({o_done, o_err}), 0);
    check({tag, "_ctrl_mode"}, 32'({o_m_control_reg, o_m_mode_reg}), 0);
    check({tag, "_addr_cnt"}, 32'({o_m_slave_addr, o_m_byte_cnt}), 0);
    check({tag, "_data"}, 32'({o_m_tx_data, o_rx_data, o_tx_next, o_rx_valid}), 0);
  endtask

  initial begin
    int s0;
    int c0;
    i_rst              = 1'b1;
    i_req              = '0;
    i_req_addr         = '0;
    i_req_cnt          = '0;
    i_req_mode         = '0;
    i_req_tx_data      = '0;
    i_m_tx_data_needed = 1'b0;
    i_m_rx_data_valid  = 1'b0;
    i_m_rx_data        = 8'h00;
    i_m_status_reg     = 5'b0;
    for (int i = 0; i < NR; i++) begin
      tx_byte[i]  = 8'(8'h10 * i + 8'h01);
      n_txnext[i] = 0;
    end
    repeat (3) step();
    check_all_zero("reset");
    i_rst = 1'b0;
    step();

    // Two simultaneous requesters with pointer 0: 1 then 2
    s0 = n_start;
    set_req(1, 10'h011, 8'd2, 2'b00);
    set_req(2, 10'h022, 8'd1, 2'b00);
    exp_done.push_back(1 * 2 + 0);
    exp_done.push_back(2 * 2 + 0);
    drain(400);
    check("rr_starts", n_start - s0, 2);
    check("rr_txnext1", n_txnext[1], 2);
    check("rr_txnext2", n_txnext[2], 1);

    // Requester 0 write, 3 bytes
    for (int i = 0; i < NR; i++) n_txnext[i] = 0;
    s0 = n_start;
    c0 = n_clear;
    set_req(0, 10'h050, 8'd3, 2'b00);
    exp_done.push_back(0);
    drain(400);
    check("wr_txnext0", n_txnext[0], 3);
    check("wr_starts", n_start - s0, 1);
    check("wr_clears", n_clear - c0, 1);
    check("wr_addr", 32'(last_addr), 32'h050);
    check("wr_cnt_mode", 32'({last_cnt, last_mode}), 32'h030);

    // Requester 2 10-bit read, 2 bytes
    rx_bytes[0] = 8'hA5;
    rx_bytes[1] = 8'h3C;
    set_req(2, 10'h2A5, 8'd2, 2'b11);
    exp_done.push_back(2 * 2 + 0);
    exp_rx.push_back(2 * 256 + 32'hA5);
    exp_rx.push_back(2 * 256 + 32'h3C);
    drain(400);
    check("rd_mode", 32'(last_mode), 32'hC);
    check("rd_addr", 32'(last_addr), 32'h2A5);

    // Requester 3 short read: 3 of 4 bytes delivered
    short_read  = 1;
    rx_bytes[0] = 8'h11;
    rx_bytes[1] = 8'h22;
    rx_bytes[2] = 8'h33;
    set_req(3, 10'h033, 8'd4, 2'b01);
    exp_done.push_back(3 * 2 + 1);
    for (int i = 0; i < 3; i++) exp_rx.push_back(3 * 256 + int'(rx_bytes[i]));
    drain(400);
    short_read = 0;

    // Master never goes busy for requester 1; requester 2 is served next
    never_busy = 1;
    gaps.delete();
    s0 = n_start;
    set_req(1, 10'h044, 8'd1, 2'b00);
    set_req(2, 10'h055, 8'd1, 2'b00);
    exp_done.push_back(1 * 2 + 1);
    exp_done.push_back(2 * 2 + 0);
    drain(600);
    check("wd_starts", n_start - s0, 2);
    check("wd_gap", (gaps.size() > 0) ? gaps[0] : -1, 65);

    // Zero byte count: error without touching the master
    s0 = n_start;
    c0 = n_clear;
    set_req(2, 10'h066, 8'd0, 2'b00);
    exp_done.push_back(2 * 2 + 1);
    drain(100);
    check("zero_starts", n_start - s0, 0);
    check("zero_clears", n_clear - c0, 0);

    // Reset in the middle of a transaction for requester 3
    for (int i = 0; i < NR; i++) n_txnext[i] = 0;
    set_req(3, 10'h077, 8'd5, 2'b00);
    begin
      int i = 0;
      while (n_txnext[3] < 2 && i < 200) begin
        step();
        i++;
      end
    end
    check("rst_reached_run", 32'(n_txnext[3] >= 2), 1);
    i_rst              = 1'b1;
    i_req              = '0;
    m_active           = 0;
    clr_prev           = 0;
    i_m_status_reg     = 5'b0;
    i_m_tx_data_needed = 1'b0;
    step();
    check_all_zero("midrst");
    repeat (2) step();
    i_rst = 1'b0;
    set_req(3, 10'h078, 8'd1, 2'b00);
    set_req(0, 10'h012, 8'd1, 2'b00);
    exp_done.push_back(0 * 2 + 0);
    exp_done.push_back(3 * 2 + 0);
    drain(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
Round-robin scheduler that shares one i2c_master instance between NUM_REQ independent requesters (sensor pollers, config loaders, CPU bridge).
It latches a granted requester's transaction descriptor and drives the master's control and mode registers.
It routes TX bytes in and RX bytes out for the granted requester, clears master status after each transaction, and returns a per-requester done/error pulse.
A watchdog recovers from a master that never goes busy or never finishes.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 64, i_clk cycles allowed between start pulse and BUSY rising
XFER_TIMEOUT, 2_000_000, i_clk cycles allowed for BUSY to fall once risen

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_req  in  NUM_REQ  per-requester transaction request, level
i_req_addr  in  10*NUM_REQ  slave address, requester k at [10k+9:10k]
i_req_cnt  in  8*NUM_REQ  byte count per requester
i_req_mode  in  2*NUM_REQ  {addr_mode(1=10-bit), rw(1=read)} per requester
i_req_tx_data  in  8*NUM_REQ  current TX byte presented by each requester
o_grant  out  NUM_REQ  one-hot, granted requester for whole transaction
o_tx_next  out  NUM_REQ  one-cycle pulse: granted requester must advance its TX byte
o_rx_valid  out  NUM_REQ  one-cycle pulse with o_rx_data for granted requester
o_rx_data  out  8  received byte
o_done  out  NUM_REQ  one-cycle completion pulse
o_err  out  NUM_REQ  one-cycle error pulse, coincident with o_done
o_m_slave_addr  out  10  to master i_slave_addr
o_m_byte_cnt  out  8  to master i_byte_cnt
o_m_control_reg  out  4  [3]=start_transaction, [2]=clear_status, [1:0]=0
o_m_mode_reg  out  4  [3]=addr_mode, [2]=rw, [1:0]=0
o_m_tx_data  out  8  to master i_tx_data
i_m_tx_data_needed  in  1  from master
i_m_rx_data_valid  in  1  from master
i_m_rx_data  in  8  from master
i_m_status_reg  in  5  [4]BUSY [3]TX_DONE [2]RX_DONE [1]TX_ERR [0]RX_ERR

Behaviour:
- Reset: state IDLE; round-robin pointer = 0, so requester 0 has top priority. All outputs 0, including o_m_* buses. Reset mid-transaction abandons it silently: no done/err pulse, and the master is not cleared.
- All outputs are registered.
- States:
  - IDLE: if any i_req, go to GRANT.
  - GRANT (1 cycle):
    - Pick the first asserted i_req scanning from pointer, wrapping NUM_REQ-1→0. Set o_grant.
    - Latch that requester's addr, cnt and mode into o_m_slave_addr / o_m_byte_cnt / o_m_mode_reg.
    - If cnt==0: go to RESP with err=1; the master is never started.
    - Otherwise go to START.
  - START (1 cycle): o_m_control_reg[3]=1, then go to WAIT_BUSY.
  - WAIT_BUSY: BUSY==1 → RUN. START_TIMEOUT cycles elapsed → CLEAR with err=1.
  - RUN:
    - o_m_tx_data is continuously the granted requester's i_req_tx_data, registered with 1-cycle latency.
    - i_m_tx_data_needed → o_tx_next[g] pulse next cycle.
    - i_m_rx_data_valid → o_rx_valid[g] and o_rx_data next cycle; the RX byte counter increments.
    - BUSY falls → CLEAR. XFER_TIMEOUT elapsed → CLEAR with err=1.
  - CLEAR (1 cycle):
    - Sample status. err |= TX_ERR | RX_ERR.
    - For a read, err |= (RX count != latched cnt).
    - For a write, err |= ~TX_DONE; for a read, err |= ~RX_DONE.
    - Drive o_m_control_reg[2]=1, then go to RESP.
  - RESP (1 cycle):
    - Pulse o_done[g], and o_err[g] if err.
    - Drop o_grant; pointer = g+1 mod NUM_REQ; go to IDLE.
- Latched descriptor: a requester changing or dropping i_req or descriptor fields after GRANT has no effect on the running transaction.
- A requester still holding i_req after o_done is re-arbitrated normally. It cannot starve others because its priority is now lowest.
- Simultaneous i_m_tx_data_needed and i_m_rx_data_valid: both forwarded in the same cycle.
- RX counter is 8 bits and saturates at 255.
- Timeout counter is sized $clog2(XFER_TIMEOUT+1) and reloads on every state entry.
- Minimum idle gap between transactions: RESP→IDLE→GRANT, i.e. 2 cycles.

Decomposition:
- Shared header i2c_pkg.vh holds:
  - status bit indices and masks (BUSY/TX_DONE/RX_DONE/TX_ERR/RX_ERR)
  - control bit indices (START=3, CLEAR=2)
  - mode bit indices (ADDR_MODE=3, RW=2)
  - the arbiter state encodings
- One sub-module, rr_arbiter: combinational round-robin pick from req vector and pointer, producing one-hot grant and binary index; parameter NUM_REQ.

Test Plan:
- i_req=4'b0110, pointer 0 → grant 4'b0010 first, then 4'b0100; each gets one start pulse on o_m_control_reg[3]; done order 1,2.
- Requester 0 write, addr 0x50, cnt 3; master model pulses tx_data_needed 3× and ends with TX_DONE → three o_tx_next[0] pulses, o_done[0]=1, o_err[0]=0, clear pulse seen.
- Requester 2 read, 10-bit addr 0x2A5, cnt 2; model returns 0xA5, 0x3C, RX_DONE → o_rx_valid[2] twice with those bytes, o_m_mode_reg=4'b1100, no error.
- Read cnt 4 but model delivers 3 bytes then clears BUSY → o_done and o_err both pulse for that requester.
- Model never raises BUSY → after 64 cycles: clear pulse, o_err pulse, next requester granted. Separately, cnt=0 request → o_err with no start pulse.
- Assert i_rst during RUN → all outputs 0 within the reset, no done pulse; after release, requester 0 is served first.
